// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and helpers for the multi-port data memory
// Contents:
//   dm_state_t   : controller state (DM_INIT clear sweep, DM_RUN normal service)
//   WORD_BYTES   : byte lanes per memory word
//   merge_bytes  : overlay the enabled byte lanes of new_word onto old_word
package dmem_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic {
        DM_INIT,
        DM_RUN
    } dm_state_t;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0]           old_word,
        input logic [31:0]           new_word,
        input logic [WORD_BYTES-1:0] en
    );
        logic [31:0] r;
        r = old_word;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (en[i]) begin
                r[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_fwd_merge.sv
// rtl/dmem_fwd_merge.sv - per-slot store-to-load forwarding merge
// Combinational. Produces the word a load on slot SLOT observes: the array
// word from before this cycle, overlaid in slot order by every older slot's
// store to the same word index.
// Ports:
//   base_word : array contents at this slot's word index
//   req/we/be/addr/wdata : all slots' request vectors (slot p at [p*W +: W])
//   merged    : forwarded read word for slot SLOT
module dmem_fwd_merge
    import dmem_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int SLOT   = 0
) (
    input  logic [31:0]              base_word,
    input  logic [NPORTS-1:0]        req,
    input  logic [NPORTS-1:0]        we,
    input  logic [4*NPORTS-1:0]      be,
    input  logic [32*NPORTS-1:0]     addr,
    input  logic [32*NPORTS-1:0]     wdata,
    output logic [31:0]              merged
);

    // Not every slot's bits matter to every instance; fold them into one sink.
    logic unused_inputs;
    assign unused_inputs = ^{req, we, be, addr, wdata};

    // Ascending slot order so the youngest older store wins each lane.
    // Full 30-bit index compare: an out-of-range store never aliases a
    // legal word.
    always_comb begin
        merged = base_word;
        for (int q = 0; q < NPORTS; q++) begin
            if (q < SLOT && req[q] && we[q] &&
                addr[q*32+2 +: 30] == addr[SLOT*32+2 +: 30]) begin
                merged = merge_bytes(merged, wdata[q*32 +: 32], be[q*4 +: 4]);
            end
        end
    end

endmodule

// File: rtl/dmem_mport.sv
// rtl/dmem_mport.sv - NPORTS-slot data memory with byte enables and forwarding
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req, we    : per-slot access request and store select
//   be, addr, wdata : per-slot byte enables, byte address, lane-aligned data
//   ready      : requests accepted this cycle (decoded from state only)
//   rvalid, rdata, oor : registered load result, one cycle after acceptance
//   init_busy  : clear sweep in progress
module dmem_mport
    import dmem_pkg::*;
#(
    parameter int NPORTS     = 2,
    parameter int DEPTH      = 1024,
    parameter int INIT_CLEAR = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NPORTS-1:0]        req,
    input  logic [NPORTS-1:0]        we,
    input  logic [4*NPORTS-1:0]      be,
    input  logic [32*NPORTS-1:0]     addr,
    input  logic [32*NPORTS-1:0]     wdata,
    output logic                     ready,
    output logic [NPORTS-1:0]        rvalid,
    output logic [32*NPORTS-1:0]     rdata,
    output logic [NPORTS-1:0]        oor,
    output logic                     init_busy
);

    localparam int AW = $clog2(DEPTH);

    dm_state_t         state;
    logic [AW-1:0]     sweep_cnt;
    logic [31:0]       mem [DEPTH];

    logic [NPORTS-1:0] in_range;
    logic [NPORTS-1:0] acc_ld;
    logic [NPORTS-1:0] acc_st;
    logic [AW-1:0]     widx      [NPORTS];
    logic [31:0]       base_word [NPORTS];
    logic [31:0]       fwd_word  [NPORTS];

    assign ready     = (state == DM_RUN);
    assign init_busy = (state == DM_INIT) && (INIT_CLEAR != 0);

    for (genvar g = 0; g < NPORTS; g++) begin : g_slot
        // Truncated index is only used for in-range accesses or is masked.
        assign widx[g]      = addr[g*32+2 +: AW];
        assign in_range[g]  = (addr[g*32+2 +: 30] < 30'(DEPTH));
        assign acc_ld[g]    = req[g] & ~we[g] & ready;
        assign acc_st[g]    = req[g] & we[g] & ready & in_range[g];
        assign base_word[g] = mem[widx[g]];

        dmem_fwd_merge #(
            .NPORTS (NPORTS),
            .SLOT   (g)
        ) u_fwd (
            .base_word (base_word[g]),
            .req       (req),
            .we        (we),
            .be        (be),
            .addr      (addr),
            .wdata     (wdata),
            .merged    (fwd_word[g])
        );
    end

    // Array has no reset; contents survive rst_n until the sweep revisits
    // them. Later slots' assignments land last, so the highest slot wins
    // each lane on a same-word conflict.
    always_ff @(posedge clk) begin
        if (rst_n && state == DM_INIT && INIT_CLEAR != 0) begin
            mem[sweep_cnt] <= '0;
        end else if (state == DM_RUN) begin
            for (int p = 0; p < NPORTS; p++) begin
                for (int l = 0; l < WORD_BYTES; l++) begin
                    if (acc_st[p] && be[p*4+l]) begin
                        mem[widx[p]][l*8 +: 8] <= wdata[p*32+l*8 +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= DM_INIT;
            sweep_cnt <= '0;
            rvalid    <= '0;
            rdata     <= '0;
            oor       <= '0;
        end else begin
            rvalid <= acc_ld;
            for (int p = 0; p < NPORTS; p++) begin
                rdata[p*32 +: 32] <= (acc_ld[p] && in_range[p]) ? fwd_word[p] : 32'h0;
                oor[p]            <= req[p] & ready & ~in_range[p];
            end
            case (state)
                DM_INIT: begin
                    if (INIT_CLEAR == 0) begin
                        state <= DM_RUN;
                    end else if (sweep_cnt == AW'(DEPTH-1)) begin
                        state <= DM_RUN;
                    end else begin
                        sweep_cnt <= sweep_cnt + 1'b1;
                    end
                end
                DM_RUN:  state <= DM_RUN;
                default: state <= DM_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mport.sv
// tb/tb_dmem_mport.sv - directed bench for dmem_mport (DEPTH 16 and DEPTH 64 instances)
module tb_dmem_mport;

    localparam int NP = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP-1:0]     req, we;
    logic [4*NP-1:0]   be;
    logic [32*NP-1:0]  addr, wdata;

    logic              a_ready, a_busy, b_ready, b_busy;
    logic [NP-1:0]     a_rvalid, a_oor, b_rvalid, b_oor;
    logic [32*NP-1:0]  a_rdata, b_rdata;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    dmem_mport #(.NPORTS(NP), .DEPTH(16), .INIT_CLEAR(1)) dut16 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .addr(addr),
        .wdata(wdata), .ready(a_ready), .rvalid(a_rvalid), .rdata(a_rdata),
        .oor(a_oor), .init_busy(a_busy)
    );

    dmem_mport #(.NPORTS(NP), .DEPTH(64), .INIT_CLEAR(1)) dut64 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .addr(addr),
        .wdata(wdata), .ready(b_ready), .rvalid(b_rvalid), .rdata(b_rdata),
        .oor(b_oor), .init_busy(b_busy)
    );

    task automatic set_slot(input int p, input logic w, input logic [3:0] b,
                            input logic [31:0] a, input logic [31:0] d);
        req[p]           = 1'b1;
        we[p]            = w;
        be[p*4 +: 4]     = b;
        addr[p*32 +: 32] = a;
        wdata[p*32 +: 32] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        req = '0;
        we  = '0;
    endtask

    // Count cycles until both sweeps finish; ready must rise with busy falling.
    task automatic sweep_wait(input string tag);
        int n, n16, n64;
        n = 0; n16 = 0; n64 = 0;
        while ((a_busy || b_busy) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
            if (!a_busy && n16 == 0) begin
                n16 = n;
                vectors++; if (a_ready !== 1'b1) begin errors++; $display("FAIL %s_ready16_rise: got %b expected 1", tag, a_ready); end
            end
            if (!b_busy && n64 == 0) n64 = n;
        end
        vectors++; if (n16 != 16) begin errors++; $display("FAIL %s_sweep16_len: got %0d expected 16", tag, n16); end
        vectors++; if (n64 != 64) begin errors++; $display("FAIL %s_sweep64_len: got %0d expected 64", tag, n64); end
        vectors++; if (b_ready !== 1'b1) begin errors++; $display("FAIL %s_ready64: got %b expected 1", tag, b_ready); end
    endtask

    function automatic logic [31:0] exp_word(input int w);
        case (w)
            8, 9:    return 32'hCAFE0000;
            12:      return 32'h123456FF;
            default: return 32'h0;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; req = '0; we = '0; be = '0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (a_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", a_ready); end
        vectors++; if (a_rvalid !== 2'b00) begin errors++; $display("FAIL rst_rvalid: got %b expected 00", a_rvalid); end
        vectors++; if (a_rdata !== 64'h0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", a_rdata); end
        vectors++; if (a_oor !== 2'b00) begin errors++; $display("FAIL rst_oor: got %b expected 00", a_oor); end
        vectors++; if (a_busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b expected 1", a_busy); end
        rst_n = 1'b1;
        sweep_wait("init");
        for (int w = 0; w < 16; w += 2) begin
            set_slot(0, 1'b0, 4'h0, 32'(w*4), 32'h0);
            set_slot(1, 1'b0, 4'h0, 32'((w+1)*4), 32'h0);
            step();
            vectors++; if (a_rvalid !== 2'b11 || a_rdata !== 64'h0) begin errors++; $display("FAIL clear16_w%0d: got v=%b d=%h expected 11/0", w, a_rvalid, a_rdata); end
            vectors++; if (b_rvalid !== 2'b11 || b_rdata !== 64'h0) begin errors++; $display("FAIL clear64_w%0d: got v=%b d=%h expected 11/0", w, b_rvalid, b_rdata); end
        end
    endtask

    task automatic test_store_load();
        set_slot(0, 1'b1, 4'hF, 32'h40, 32'hDEADBEEF);
        step();
        vectors++; if (b_rvalid !== 2'b00) begin errors++; $display("FAIL st_no_rvalid: got %b expected 00", b_rvalid); end
        vectors++; if (a_oor !== 2'b01) begin errors++; $display("FAIL st_oor16: got %b expected 01", a_oor); end
        set_slot(1, 1'b0, 4'h0, 32'h40, 32'h0);
        step();
        vectors++; if (b_rvalid !== 2'b10) begin errors++; $display("FAIL ld_rvalid: got %b expected 10", b_rvalid); end
        vectors++; if (b_rdata[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_rdata: got %h expected deadbeef", b_rdata[63:32]); end
        vectors++; if (b_oor !== 2'b00) begin errors++; $display("FAIL ld_oor: got %b expected 00", b_oor); end
        step();
        vectors++; if (b_rvalid !== 2'b00 || b_rdata !== 64'h0) begin errors++; $display("FAIL ld_one_cycle: got v=%b d=%h expected 00/0", b_rvalid, b_rdata); end
    endtask

    task automatic test_write_conflict();
        set_slot(0, 1'b1, 4'hF, 32'h80, 32'h11223344);
        set_slot(1, 1'b1, 4'b0011, 32'h80, 32'hAABBCCDD);
        step();
        set_slot(0, 1'b0, 4'h0, 32'h80, 32'h0);
        step();
        vectors++; if (b_rdata[31:0] !== 32'h1122CCDD) begin errors++; $display("FAIL conflict: got %h expected 1122ccdd", b_rdata[31:0]); end
    endtask

    task automatic test_forwarding();
        set_slot(0, 1'b1, 4'b1100, 32'h20, 32'hCAFEF00D);
        set_slot(1, 1'b0, 4'h0, 32'h20, 32'h0);
        step();
        vectors++; if (b_rvalid !== 2'b10 || b_rdata[63:32] !== 32'hCAFE0000) begin errors++; $display("FAIL fwd_older: got v=%b d=%h expected 10/cafe0000", b_rvalid, b_rdata[63:32]); end
        vectors++; if (a_rdata[63:32] !== 32'hCAFE0000) begin errors++; $display("FAIL fwd_older16: got %h expected cafe0000", a_rdata[63:32]); end
        set_slot(1, 1'b1, 4'b1100, 32'h24, 32'hCAFEF00D);
        set_slot(0, 1'b0, 4'h0, 32'h24, 32'h0);
        step();
        vectors++; if (b_rvalid !== 2'b01 || b_rdata[31:0] !== 32'h0) begin errors++; $display("FAIL fwd_younger: got v=%b d=%h expected 01/0", b_rvalid, b_rdata[31:0]); end
        set_slot(0, 1'b0, 4'h0, 32'h24, 32'h0);
        step();
        vectors++; if (b_rdata[31:0] !== 32'hCAFE0000) begin errors++; $display("FAIL younger_commit: got %h expected cafe0000", b_rdata[31:0]); end
        set_slot(0, 1'b1, 4'hF, 32'h30, 32'h12345678);
        step();
        set_slot(0, 1'b1, 4'b0001, 32'h30, 32'hAAAAAAFF);
        set_slot(1, 1'b0, 4'h0, 32'h30, 32'h0);
        step();
        vectors++; if (b_rdata[63:32] !== 32'h123456FF) begin errors++; $display("FAIL fwd_mix: got %h expected 123456ff", b_rdata[63:32]); end
    endtask

    task automatic test_oor();
        set_slot(0, 1'b1, 4'hF, 32'h100, 32'hFFFFFFFF);
        set_slot(1, 1'b0, 4'h0, 32'h104, 32'h0);
        step();
        vectors++; if (a_oor !== 2'b11) begin errors++; $display("FAIL oor16: got %b expected 11", a_oor); end
        vectors++; if (a_rvalid !== 2'b10 || a_rdata !== 64'h0) begin errors++; $display("FAIL oor16_data: got v=%b d=%h expected 10/0", a_rvalid, a_rdata); end
        vectors++; if (b_oor !== 2'b11) begin errors++; $display("FAIL oor64: got %b expected 11", b_oor); end
        step();
        vectors++; if (a_oor !== 2'b00) begin errors++; $display("FAIL oor_one_cycle: got %b expected 00", a_oor); end
        for (int w = 0; w < 16; w += 2) begin
            set_slot(0, 1'b0, 4'h0, 32'(w*4), 32'h0);
            set_slot(1, 1'b0, 4'h0, 32'((w+1)*4), 32'h0);
            step();
            vectors++; if (a_rdata !== {exp_word(w+1), exp_word(w)}) begin errors++; $display("FAIL keep16_w%0d: got %h expected %h", w, a_rdata, {exp_word(w+1), exp_word(w)}); end
            vectors++; if (b_rdata !== {exp_word(w+1), exp_word(w)}) begin errors++; $display("FAIL keep64_w%0d: got %h expected %h", w, b_rdata, {exp_word(w+1), exp_word(w)}); end
        end
    endtask

    task automatic test_reset_midway();
        set_slot(0, 1'b0, 4'h0, 32'h30, 32'h0);
        step();
        vectors++; if (a_rvalid !== 2'b01 || a_rdata[31:0] !== 32'h123456FF) begin errors++; $display("FAIL inflight: got v=%b d=%h expected 01/123456ff", a_rvalid, a_rdata[31:0]); end
        rst_n = 1'b0;
        #1;
        vectors++; if (a_rvalid !== 2'b00 || a_rdata !== 64'h0) begin errors++; $display("FAIL run_rst_drop: got v=%b d=%h expected 00/0", a_rvalid, a_rdata); end
        vectors++; if (a_ready !== 1'b0 || a_busy !== 1'b1) begin errors++; $display("FAIL run_rst_state: got r=%b b=%b expected 0/1", a_ready, a_busy); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        vectors++; if (a_busy !== 1'b1 || a_ready !== 1'b0) begin errors++; $display("FAIL mid_sweep: got b=%b r=%b expected 1/0", a_busy, a_ready); end
        rst_n = 1'b0;
        #1;
        vectors++; if (a_ready !== 1'b0 || a_busy !== 1'b1) begin errors++; $display("FAIL sweep_rst: got r=%b b=%b expected 0/1", a_ready, a_busy); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sweep_wait("restart");
        set_slot(0, 1'b0, 4'h0, 32'h30, 32'h0);
        set_slot(1, 1'b0, 4'h0, 32'h20, 32'h0);
        step();
        vectors++; if (a_rvalid !== 2'b11 || a_rdata !== 64'h0) begin errors++; $display("FAIL reswept16: got v=%b d=%h expected 11/0", a_rvalid, a_rdata); end
        vectors++; if (b_rdata !== 64'h0) begin errors++; $display("FAIL reswept64: got %h expected 0", b_rdata); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_write_conflict();
        test_forwarding();
        test_oor();
        test_reset_midway();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
